crc8_rx_checker: RTL and testbench

- Streaming CRC-8 checker for inbound byte frames from the host link, placed between the byte deframer and the command decoder.
- Each frame is payload bytes followed by one trailing CRC byte; `i_s_last` marks the CRC byte.
- Uses the existing combinational crc8 stage (poly 0x07, MSB-first) per accepted byte, strips the CRC byte and forwards the payload with a per-frame pass/fail flag on the last payload beat.
- Full throughput: 1 byte/cycle.

---
 rtl/crc8_rx_checker_pkg.sv | 19 +
 rtl/crc8_rx_checker_crc8.sv | 12 +
 rtl/crc8_rx_checker.sv | 105 ++++++++++
 tb/tb_crc8_rx_checker.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc8_rx_checker_pkg.sv
// Shared CRC-8 constants and the bit-serial update function (poly 0x07, MSB-first, no reflection, no xorout).
package crc8_rx_checker_pkg;

    localparam logic [7:0] CRC8_POLY         = 8'h07;
    localparam logic [7:0] CRC8_RESIDUE      = 8'h00;
    localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;
    localparam int         CRC8_STATS_W      = 16;

    // One full byte of CRC update, shifting out the MSB first.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_rx_checker_crc8.sv
// Combinational CRC-8 stage: folds one data byte into the running CRC value.
module crc8
    import crc8_rx_checker_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic [7:0] i_data,
    output logic [7:0] o_crc
);

    assign o_crc = crc8_next(i_crc, i_data);

endmodule

// File: rtl/crc8_rx_checker.sv
// Streaming CRC-8 frame checker: strips the trailing CRC byte and flags the last payload beat.
// Optional frame counters are enabled by defining CRC8_RX_CHECKER_STATS_EN.
module crc8_rx_checker
    import crc8_rx_checker_pkg::*;
#(
    parameter logic [7:0] CRC_INIT = CRC8_INIT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_s_data,
    input  logic       i_s_valid,
    input  logic       i_s_last,
    output logic       o_s_ready,
    output logic [7:0] o_m_data,
    output logic       o_m_valid,
    output logic       o_m_last,
    output logic       o_m_crc_ok,
    input  logic       i_m_ready,
    output logic       o_runt
`ifdef CRC8_RX_CHECKER_STATS_EN
    ,
    input  logic                    i_cnt_clr,
    output logic [CRC8_STATS_W-1:0] o_cnt_ok,
    output logic [CRC8_STATS_W-1:0] o_cnt_err
`endif
);

    logic [7:0] crc_q;
    logic [7:0] crc_nxt;
    logic [7:0] hold_q;
    logic       hold_vld;
    logic       accept;
    logic       m_xfer;
    logic       crc_match;

    crc8 u_crc8 (
        .i_crc  (crc_q),
        .i_data (i_s_data),
        .o_crc  (crc_nxt)
    );

    assign o_s_ready = !o_m_valid | i_m_ready;
    assign accept    = i_s_valid & o_s_ready;
    assign m_xfer    = o_m_valid & i_m_ready;
    assign crc_match = (crc_nxt == CRC8_RESIDUE);

    // The hold register keeps one payload byte back so the final payload beat can carry the verdict.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_m_valid  <= 1'b0;
            o_m_last   <= 1'b0;
            o_m_crc_ok <= 1'b0;
            o_m_data   <= 8'h00;
            o_runt     <= 1'b0;
            hold_q     <= 8'h00;
            hold_vld   <= 1'b0;
            crc_q      <= CRC_INIT;
        end else begin
            o_runt <= 1'b0;
            if (accept && hold_vld) begin
                o_m_valid  <= 1'b1;
                o_m_data   <= hold_q;
                o_m_last   <= i_s_last;
                o_m_crc_ok <= i_s_last & crc_match;
            end else if (m_xfer) begin
                o_m_valid <= 1'b0;
            end
            if (accept) begin
                if (i_s_last) begin
                    crc_q    <= CRC_INIT;
                    hold_vld <= 1'b0;
                    o_runt   <= !hold_vld;
                end else begin
                    crc_q    <= crc_nxt;
                    hold_q   <= i_s_data;
                    hold_vld <= 1'b1;
                end
            end
        end
    end

`ifdef CRC8_RX_CHECKER_STATS_EN
    logic frame_ok;
    logic frame_err;

    assign frame_ok  = accept & i_s_last & hold_vld & crc_match;
    assign frame_err = accept & i_s_last & !(hold_vld & crc_match);

    // Counters move when the verdict is produced, not when downstream takes it; clear beats increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            o_cnt_ok  <= '0;
            o_cnt_err <= '0;
        end else begin
            if (frame_ok && (o_cnt_ok != '1)) begin
                o_cnt_ok <= o_cnt_ok + CRC8_STATS_W'(1);
            end
            if (frame_err && (o_cnt_err != '1)) begin
                o_cnt_err <= o_cnt_err + CRC8_STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_crc8_rx_checker.sv
// Self-checking bench for crc8_rx_checker: directed frames plus random traffic against a polynomial-division model.
// Two instances share the stimulus, one with the default init and one with CRC_INIT=8'hFF.
module tb_crc8_rx_checker;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       ok;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       m_ready = 1'b1;

    logic       s_ready1, m_valid1, m_last1, m_ok1, runt1;
    logic [7:0] m_data1;
    logic       s_ready2, m_valid2, m_last2, m_ok2, runt2;
    logic [7:0] m_data2;
`ifdef CRC8_RX_CHECKER_STATS_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] cnt_ok1, cnt_err1, cnt_ok2, cnt_err2;
`endif

    int    n_cmp = 0;
    int    n_fail = 0;
    beat_t got1[$], got2[$], exp1[$], exp2[$];
    int    runt_got1 = 0, runt_got2 = 0, runt_exp = 0;
    int    mod_ok = 0, mod_err = 0;
    int    rmode = 0, rk = 0;
    beat_t prev1;
    bit    stalled1 = 1'b0;

    crc8_rx_checker dut1 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_s_data   (s_data),
        .i_s_valid  (s_valid),
        .i_s_last   (s_last),
        .o_s_ready  (s_ready1),
        .o_m_data   (m_data1),
        .o_m_valid  (m_valid1),
        .o_m_last   (m_last1),
        .o_m_crc_ok (m_ok1),
        .i_m_ready  (m_ready),
        .o_runt     (runt1)
`ifdef CRC8_RX_CHECKER_STATS_EN
        ,
        .i_cnt_clr  (cnt_clr),
        .o_cnt_ok   (cnt_ok1),
        .o_cnt_err  (cnt_err1)
`endif
    );

    crc8_rx_checker #(.CRC_INIT(8'hFF)) dut2 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_s_data   (s_data),
        .i_s_valid  (s_valid),
        .i_s_last   (s_last),
        .o_s_ready  (s_ready2),
        .o_m_data   (m_data2),
        .o_m_valid  (m_valid2),
        .o_m_last   (m_last2),
        .o_m_crc_ok (m_ok2),
        .i_m_ready  (m_ready),
        .o_runt     (runt2)
`ifdef CRC8_RX_CHECKER_STATS_EN
        ,
        .i_cnt_clr  (cnt_clr),
        .o_cnt_ok   (cnt_ok2),
        .o_cnt_err  (cnt_err2)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // CRC as the remainder of M(x)*x^8 mod (x^8+x^2+x+1); a non-zero init is folded into the first byte.
    function automatic logic [7:0] ref_crc(input logic [7:0] init, input byte_q_t msg);
        bit         bits[$];
        logic [8:0] poly;
        logic [7:0] r;
        logic [7:0] v;
        poly = 9'h107;
        r = init;
        if (msg.size() == 0) return r;
        for (int i = 0; i < msg.size(); i++) begin
            v = (i == 0) ? (msg[i] ^ init) : msg[i];
            for (int k = 7; k >= 0; k--) bits.push_back(v[k]);
        end
        for (int k = 0; k < 8; k++) bits.push_back(1'b0);
        for (int i = 0; i + 8 < bits.size(); i++) begin
            if (bits[i]) begin
                for (int k = 0; k < 9; k++) bits[i + k] = bits[i + k] ^ poly[8 - k];
            end
        end
        for (int k = 0; k < 8; k++) r[7 - k] = bits[bits.size() - 8 + k];
        return r;
    endfunction

    // Downstream ready patterns: 0 always, 1 toggling, 2 random, 3 toggling with a 5-cycle low stretch.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rk++;
            case (rmode)
                1:       m_ready = (rk % 2 == 0);
                2:       m_ready = ($urandom_range(0, 1) == 1);
                3:       m_ready = ((rk % 16) >= 4 && (rk % 16) < 9) ? 1'b0 : (rk % 2 == 0);
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Collect outbound transfers and runt pulses; a stalled beat must not change.
    always @(negedge clk) begin
        if (!rst) begin
            if (stalled1) check("stall_hold", {m_valid1, m_data1, m_last1, m_ok1}, {1'b1, prev1});
            if (m_valid1 === 1'b1 && m_ready === 1'b1) got1.push_back(beat_t'({m_data1, m_last1, m_ok1}));
            if (m_valid2 === 1'b1 && m_ready === 1'b1) got2.push_back(beat_t'({m_data2, m_last2, m_ok2}));
            if (runt1 === 1'b1) runt_got1++;
            if (runt2 === 1'b1) runt_got2++;
            stalled1 = (m_valid1 === 1'b1) && (m_ready === 1'b0);
            prev1 = beat_t'({m_data1, m_last1, m_ok1});
        end else begin
            stalled1 = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        s_data = b;
        s_last = last;
        s_valid = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = (s_ready1 === 1'b1);
            step();
            guard++;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        check("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic applyStimulus(input byte_q_t p, input logic [7:0] c, input bit gaps);
        bit ok1, ok2, is_last;
        for (int i = 0; i < p.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) step();
            send_byte(p[i], 1'b0);
        end
        if (gaps && $urandom_range(0, 3) == 0) step();
        send_byte(c, 1'b1);
        ok1 = (ref_crc(8'h00, p) == c);
        ok2 = (ref_crc(8'hFF, p) == c);
        if (p.size() == 0) begin
            runt_exp++;
            mod_err++;
        end else begin
            for (int i = 0; i < p.size(); i++) begin
                is_last = (i == p.size() - 1);
                exp1.push_back(beat_t'({p[i], is_last, is_last & ok1}));
                exp2.push_back(beat_t'({p[i], is_last, is_last & ok2}));
            end
            if (ok1) mod_ok++;
            else     mod_err++;
        end
    endtask

    task automatic checkOutput(input string tag);
        int guard;
        guard = 0;
        while ((got1.size() < exp1.size() || got2.size() < exp2.size()) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_count1"}, got1.size(), exp1.size());
        check({tag, "_count2"}, got2.size(), exp2.size());
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) check({tag, "_beat1"}, got1[i], exp1[i]);
        for (int i = 0; i < exp2.size() && i < got2.size(); i++) check({tag, "_beat2"}, got2[i], exp2[i]);
        check({tag, "_runt1"}, runt_got1, runt_exp);
        check({tag, "_runt2"}, runt_got2, runt_exp);
`ifdef CRC8_RX_CHECKER_STATS_EN
        check({tag, "_cnt_ok"}, cnt_ok1, mod_ok);
        check({tag, "_cnt_err"}, cnt_err1, mod_err);
`endif
        step();
    endtask

    task automatic clear_all();
        got1.delete();
        got2.delete();
        exp1.delete();
        exp2.delete();
        runt_got1 = 0;
        runt_got2 = 0;
        runt_exp = 0;
    endtask

    initial begin
        byte_q_t good, one_byte, single00, empty_q, rnd;
        logic [7:0] c;
        int nlast;
        good     = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        one_byte = '{8'h01};
        single00 = '{8'h00};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", m_valid1, 1'b0);
        check("rst_last", m_last1, 1'b0);
        check("rst_ok", m_ok1, 1'b0);
        check("rst_data", m_data1, 8'h00);
        check("rst_runt", runt1, 1'b0);
        check("rst_ready", s_ready1, 1'b1);
        check("rst_valid2", m_valid2, 1'b0);
        step();

        $display("[TB] good frame");
        applyStimulus(good, 8'hF4, 1'b0);
        checkOutput("good");
        check("good_final", got1[8], {8'h39, 1'b1, 1'b1});
        clear_all();

        $display("[TB] bad crc");
        applyStimulus(good, 8'hF5, 1'b0);
        checkOutput("bad");
        check("bad_final", got1[8], {8'h39, 1'b1, 1'b0});
        clear_all();

        $display("[TB] minimal frame then runt");
        applyStimulus(one_byte, 8'h07, 1'b0);
        applyStimulus(empty_q, 8'h00, 1'b0);
        checkOutput("min_runt");
        check("min_beat", got1[0], {8'h01, 1'b1, 1'b1});
        check("runt_once", runt_got1, 1);
        clear_all();

        $display("[TB] backpressure");
        rmode = 1;
        applyStimulus(good, 8'hF4, 1'b0);
        checkOutput("bp_toggle");
        clear_all();
        rk = 0;
        rmode = 3;
        applyStimulus(good, 8'hF4, 1'b1);
        checkOutput("bp_stall");
        check("bp_final", got1[8], {8'h39, 1'b1, 1'b1});
        clear_all();
        rmode = 0;
        step();

        $display("[TB] reset mid-frame");
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_valid", m_valid1, 1'b0);
        repeat (3) @(negedge clk);
        nlast = 0;
        foreach (got1[i]) if (got1[i].last) nlast++;
        check("rstmid_nolast", nlast, 0);
        check("rstmid_norunt", runt_got1, 0);
        clear_all();
        mod_ok = 0;
        mod_err = 0;
        step();
        applyStimulus(good, 8'hF4, 1'b0);
        checkOutput("rstmid_next");
        clear_all();

        $display("[TB] non-default init");
        applyStimulus(single00, 8'hF3, 1'b0);
        checkOutput("init_ff_good");
        check("init_ff_good_beat", got2[0], {8'h00, 1'b1, 1'b1});
        clear_all();
        applyStimulus(single00, 8'h00, 1'b0);
        checkOutput("init_ff_bad");
        check("init_ff_bad_beat", got2[0], {8'h00, 1'b1, 1'b0});
        clear_all();

        $display("[TB] random frames");
        rmode = 2;
        for (int f = 0; f < 25; f++) begin
            rnd.delete();
            for (int i = 0; i < $urandom_range(0, 6); i++) rnd.push_back(8'($urandom));
            c = ($urandom_range(0, 1) == 1) ? ref_crc(8'h00, rnd) : 8'($urandom);
            applyStimulus(rnd, c, 1'b1);
        end
        checkOutput("random");
        clear_all();
        rmode = 0;

`ifdef CRC8_RX_CHECKER_STATS_EN
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_clr_ok", cnt_ok1, 16'd0);
        check("cnt_clr_err", cnt_err1, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
